pipe_hazard_unit: RTL and testbench

- Hazard-detection and forwarding-control block for the pipelined successor of the single-cycle core.
- Tracks destination registers in flight across a configurable number of post-decode stages.
- Drives fetch/decode stall and squash, and produces per-operand forwarding selects for the execute-stage operand muxes.
- Sits beside decode/control; consumes decoded fields and the execute-stage redirect, and is otherwise stateless w.r.t. datapath values.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/sat_counter.sv | 30 +++
 rtl/pipe_hazard_unit.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding unit.
// Tracking entries store rd zero-extended to MaxRaw bits so the struct stays fixed-width.
package pipe_pkg;

  localparam int unsigned MaxRaw     = 8;
  localparam int unsigned FWD_SRC_RF = 0;

  typedef struct packed {
    logic              valid;
    logic [MaxRaw-1:0] rd;
    logic              is_load;
  } hz_entry_t;

  function automatic int unsigned sel_width(input int unsigned nstages);
    return $clog2(nstages + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on clk when inc_i is set, sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_i,
  output logic [CNTW-1:0] cnt_o
);

  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and forwarding control: tracks in-flight destination registers
// and drives stall/flush plus per-operand forwarding selects for the EX operand muxes.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned NSTAGES = 3,
  parameter int unsigned RAW     = 5,
  parameter bit          FWD_EN  = 1'b1,
  parameter int unsigned CNTW    = 32,
  localparam int unsigned SELW   = sel_width(NSTAGES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_valid_i,
  input  logic [RAW-1:0]     d_rs1_i,
  input  logic [RAW-1:0]     d_rs2_i,
  input  logic               d_uses_rs1_i,
  input  logic               d_uses_rs2_i,
  input  logic [RAW-1:0]     d_rd_i,
  input  logic               d_regwr_i,
  input  logic               d_is_load_i,
  input  logic               redirect_i,
  output logic               stall_o,
  output logic               flush_o,
  output logic [SELW-1:0]    fwd_rs1_sel_o,
  output logic [SELW-1:0]    fwd_rs2_sel_o,
  output logic [NSTAGES-1:0] stage_valid_o,
  output logic [CNTW-1:0]    stall_cnt_o,
  output logic [CNTW-1:0]    flush_cnt_o
);

  hz_entry_t stage_q [NSTAGES];
  hz_entry_t stage_d [NSTAGES];

  logic [MaxRaw-1:0] rs1_w, rs2_w, rd_w;
  logic              rs1_hit, rs2_hit;
  logic [SELW-1:0]   rs1_idx, rs2_idx;
  logic              hazard, issue;

  assign rs1_w = MaxRaw'(d_rs1_i);
  assign rs2_w = MaxRaw'(d_rs2_i);
  assign rd_w  = MaxRaw'(d_rd_i);

  function automatic logic entry_hit(hz_entry_t e, logic uses, logic [MaxRaw-1:0] rs);
    return uses && (rs != '0) && e.valid && (e.rd == rs);
  endfunction

  // Scan oldest to youngest so the youngest matching stage overwrites the result.
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    rs1_idx = '0;
    rs2_idx = '0;
    for (int k = int'(NSTAGES) - 1; k >= 0; k--) begin
      if (entry_hit(stage_q[k], d_uses_rs1_i, rs1_w)) begin
        rs1_hit = 1'b1;
        rs1_idx = SELW'(k);
      end
      if (entry_hit(stage_q[k], d_uses_rs2_i, rs2_w)) begin
        rs2_hit = 1'b1;
        rs2_idx = SELW'(k);
      end
    end
  end

  // Without forwarding, a WB-stage producer is covered by regfile write-before-read.
  always_comb begin
    if (FWD_EN) begin
      hazard = stage_q[0].is_load &&
               ((rs1_hit && (rs1_idx == '0)) || (rs2_hit && (rs2_idx == '0)));
    end else begin
      hazard = (rs1_hit && (rs1_idx <= SELW'(NSTAGES - 2))) ||
               (rs2_hit && (rs2_idx <= SELW'(NSTAGES - 2)));
    end
  end

  always_comb begin
    stall_o       = d_valid_i && hazard && !redirect_i;
    flush_o       = redirect_i && rst;
    issue         = d_valid_i && !stall_o && !redirect_i;
    fwd_rs1_sel_o = (FWD_EN && !stall_o && rs1_hit) ? rs1_idx + SELW'(1) : SELW'(FWD_SRC_RF);
    fwd_rs2_sel_o = (FWD_EN && !stall_o && rs2_hit) ? rs2_idx + SELW'(1) : SELW'(FWD_SRC_RF);
  end

  always_comb begin
    stage_d[0] = '0;
    if (issue && d_regwr_i && (d_rd_i != '0)) begin
      stage_d[0] = '{valid: 1'b1, rd: rd_w, is_load: d_is_load_i};
    end
    for (int k = 1; k < int'(NSTAGES); k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(NSTAGES); k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NSTAGES); k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  always_comb begin
    stage_valid_o = '0;
    for (int k = 0; k < int'(NSTAGES); k++) begin
      stage_valid_o[k] = stage_q[k].valid;
    end
  end

  sat_counter #(
    .CNTW (CNTW)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(
    .CNTW (CNTW)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench: instance A forwards (FWD_EN=1), instance B is stall-only with 2-bit counters.
module tb_pipe_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_valid, a_u1, a_u2, a_wr, a_ld, a_redir;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic       a_stall, a_flush;
  logic [1:0] a_s1, a_s2;
  logic [2:0] a_sv;
  logic [31:0] a_scnt, a_fcnt;

  logic       b_valid, b_u1, b_u2, b_wr, b_ld, b_redir;
  logic [4:0] b_rs1, b_rs2, b_rd;
  logic       b_stall, b_flush;
  logic [1:0] b_s1, b_s2;
  logic [2:0] b_sv;
  logic [1:0] b_scnt, b_fcnt;

  pipe_hazard_unit #(
    .NSTAGES (3),
    .RAW     (5),
    .FWD_EN  (1'b1),
    .CNTW    (32)
  ) u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .d_valid_i     (a_valid),
    .d_rs1_i       (a_rs1),
    .d_rs2_i       (a_rs2),
    .d_uses_rs1_i  (a_u1),
    .d_uses_rs2_i  (a_u2),
    .d_rd_i        (a_rd),
    .d_regwr_i     (a_wr),
    .d_is_load_i   (a_ld),
    .redirect_i    (a_redir),
    .stall_o       (a_stall),
    .flush_o       (a_flush),
    .fwd_rs1_sel_o (a_s1),
    .fwd_rs2_sel_o (a_s2),
    .stage_valid_o (a_sv),
    .stall_cnt_o   (a_scnt),
    .flush_cnt_o   (a_fcnt)
  );

  pipe_hazard_unit #(
    .NSTAGES (3),
    .RAW     (5),
    .FWD_EN  (1'b0),
    .CNTW    (2)
  ) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .d_valid_i     (b_valid),
    .d_rs1_i       (b_rs1),
    .d_rs2_i       (b_rs2),
    .d_uses_rs1_i  (b_u1),
    .d_uses_rs2_i  (b_u2),
    .d_rd_i        (b_rd),
    .d_regwr_i     (b_wr),
    .d_is_load_i   (b_ld),
    .redirect_i    (b_redir),
    .stall_o       (b_stall),
    .flush_o       (b_flush),
    .fwd_rs1_sel_o (b_s1),
    .fwd_rs2_sel_o (b_s2),
    .stage_valid_o (b_sv),
    .stall_cnt_o   (b_scnt),
    .flush_cnt_o   (b_fcnt)
  );

  typedef struct {
    bit    dut;
    string tag;
    int    stall;
    int    flush;
    int    s1;
    int    s2;
    int    sv;
    int    scnt;
    int    fcnt;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string tag, input string field, input logic [31:0] act,
                     input int expv);
    checks++;
    if (act !== 32'(expv)) begin
      errors++;
      $display("FAIL %s.%s: got %0d, expected %0d", tag, field, act, expv);
    end
  endtask

  // Monitor: every negedge, check whatever the driver queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e.dut) begin
          cmp(e.tag, "stall", 32'(a_stall), e.stall);
          cmp(e.tag, "flush", 32'(a_flush), e.flush);
          cmp(e.tag, "sel1", 32'(a_s1), e.s1);
          cmp(e.tag, "sel2", 32'(a_s2), e.s2);
          cmp(e.tag, "stage_valid", 32'(a_sv), e.sv);
          cmp(e.tag, "stall_cnt", a_scnt, e.scnt);
          cmp(e.tag, "flush_cnt", a_fcnt, e.fcnt);
        end else begin
          cmp(e.tag, "stall", 32'(b_stall), e.stall);
          cmp(e.tag, "flush", 32'(b_flush), e.flush);
          cmp(e.tag, "sel1", 32'(b_s1), e.s1);
          cmp(e.tag, "sel2", 32'(b_s2), e.s2);
          cmp(e.tag, "stage_valid", 32'(b_sv), e.sv);
          cmp(e.tag, "stall_cnt", 32'(b_scnt), e.scnt);
          cmp(e.tag, "flush_cnt", 32'(b_fcnt), e.fcnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input bit dut, input string tag, input int st, input int fl, input int s1,
                     input int s2, input int sv, input int sc, input int fc);
    exp_t e;
    e = '{dut: dut, tag: tag, stall: st, flush: fl, s1: s1, s2: s2, sv: sv, scnt: sc, fcnt: fc};
    exp_q.push_back(e);
  endtask

  task automatic drv_a(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit rdr);
    a_valid = v; a_rs1 = 5'(rs1); a_rs2 = 5'(rs2); a_u1 = u1; a_u2 = u2;
    a_rd = 5'(rd); a_wr = wr; a_ld = ld; a_redir = rdr;
  endtask

  task automatic drv_b(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit rdr);
    b_valid = v; b_rs1 = 5'(rs1); b_rs2 = 5'(rs2); b_u1 = u1; b_u2 = u2;
    b_rd = 5'(rd); b_wr = wr; b_ld = ld; b_redir = rdr;
  endtask

  initial begin
    drv_a(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drv_b(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Instance A: forwarding mode. stage_valid bit k = stage k.
    tick(); chk(0, "reset", 0, 0, 0, 0, 'b000, 0, 0);
    tick(); rst = 1'b1;
    drv_a(1, 0, 0, 0, 0, 5, 1, 1, 0);   chk(0, "lw_x5", 0, 0, 0, 0, 'b000, 0, 0);
    tick(); drv_a(1, 5, 1, 1, 1, 6, 1, 0, 0); chk(0, "load_use", 1, 0, 0, 0, 'b001, 0, 0);
    tick(); drv_a(1, 5, 1, 1, 1, 6, 1, 0, 0); chk(0, "load_use_mem", 0, 0, 2, 0, 'b010, 1, 0);
    tick(); drv_a(1, 0, 0, 1, 0, 3, 1, 0, 0); chk(0, "addi_x3", 0, 0, 0, 0, 'b101, 1, 0);
    tick(); drv_a(1, 3, 3, 1, 1, 4, 1, 0, 0); chk(0, "alu_alu", 0, 0, 1, 1, 'b011, 1, 0);
    tick(); drv_a(1, 0, 0, 1, 0, 7, 1, 0, 0); chk(0, "addi_x7a", 0, 0, 0, 0, 'b111, 1, 0);
    tick(); drv_a(1, 0, 0, 1, 0, 7, 1, 0, 0); chk(0, "addi_x7b", 0, 0, 0, 0, 'b111, 1, 0);
    tick(); drv_a(1, 7, 4, 1, 1, 8, 1, 0, 0); chk(0, "youngest_wb", 0, 0, 1, 3, 'b111, 1, 0);
    tick(); drv_a(1, 0, 0, 1, 0, 0, 1, 0, 0); chk(0, "rd0_writer", 0, 0, 0, 0, 'b111, 1, 0);
    tick(); drv_a(1, 0, 0, 1, 1, 9, 0, 0, 0); chk(0, "x0_reader", 0, 0, 0, 0, 'b110, 1, 0);
    tick(); drv_a(1, 0, 0, 0, 0, 10, 1, 1, 0); chk(0, "lw_x10", 0, 0, 0, 0, 'b100, 1, 0);
    // Load-use with a simultaneous redirect: flush wins, no stall.
    tick(); drv_a(1, 10, 0, 1, 0, 11, 1, 0, 1); chk(0, "redirect", 0, 1, 1, 0, 'b001, 1, 0);
    tick(); drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0);  chk(0, "post_redirect", 0, 0, 0, 0, 'b010, 1, 1);

    // Instance B: stall-only, 2-bit saturating counters.
    tick(); drv_b(1, 0, 0, 1, 0, 12, 1, 0, 0);    chk(1, "b_addi", 0, 0, 0, 0, 'b000, 0, 0);
    tick(); drv_b(1, 12, 12, 1, 1, 13, 1, 0, 0);  chk(1, "b_raw_ex", 1, 0, 0, 0, 'b001, 0, 0);
    tick(); drv_b(1, 12, 12, 1, 1, 13, 1, 0, 0);  chk(1, "b_raw_mem", 1, 0, 0, 0, 'b010, 1, 0);
    tick(); drv_b(1, 12, 12, 1, 1, 13, 1, 0, 0);  chk(1, "b_wb_release", 0, 0, 0, 0, 'b100, 2, 0);
    tick(); drv_b(1, 13, 0, 1, 0, 14, 1, 0, 0);   chk(1, "b_stall_a", 1, 0, 0, 0, 'b001, 2, 0);
    tick(); drv_b(1, 13, 0, 1, 0, 14, 1, 0, 0);   chk(1, "b_stall_b", 1, 0, 0, 0, 'b010, 3, 0);
    tick(); drv_b(1, 13, 0, 1, 0, 14, 1, 0, 0);   chk(1, "b_saturate", 0, 0, 0, 0, 'b100, 3, 0);
    tick(); drv_b(1, 14, 0, 1, 0, 15, 1, 0, 0);   chk(1, "b_stall_c", 1, 0, 0, 0, 'b001, 3, 0);
    // Asynchronous reset in the middle of a stall: visible before the next edge.
    tick(); rst = 1'b0;                           chk(1, "b_async_rst", 0, 0, 0, 0, 'b000, 0, 0);
    tick(); rst = 1'b1;
    drv_b(1, 14, 0, 1, 0, 15, 1, 0, 1);           chk(1, "b_redirect", 0, 1, 0, 0, 'b000, 0, 0);
    tick(); drv_b(0, 0, 0, 0, 0, 0, 0, 0, 0);     chk(1, "b_flush_cnt", 0, 0, 0, 0, 'b000, 0, 1);

    tick();
    tick();
    cmp("end", "queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
